// File: rtl/dbram_if.sv
// Data local-memory bus between the load/store BRAM sub-unit and its responder.
// Carries the core request/response signals and the preload streaming channel.
interface dbram_if #(
   parameter int DEPTH = 4096
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [29:0]      addr;
   logic             en;
   logic [3:0]       be;
   logic [31:0]      data_in;
   logic [31:0]      data_out;
   logic             load_start;
   logic [IDX_W-1:0] load_base;
   logic [IDX_W:0]   load_len;
   logic             load_valid;
   logic [31:0]      load_data;
   logic             load_ready;
   logic             load_busy;
   logic             load_done;

   modport master (
      output addr, en, be, data_in,
      output load_start, load_base, load_len,
      output load_valid, load_data,
      input  data_out, load_ready, load_busy, load_done
   );

   modport slave (
      input  addr, en, be, data_in,
      input  load_start, load_base, load_len,
      input  load_valid, load_data,
      output data_out, load_ready, load_busy, load_done
   );
endinterface

// File: rtl/dbram_responder.sv
// Data BRAM responder: byte-enabled core port with 1-cycle read-first reads,
// plus a valid/ready preload channel that yields to the core port.
// Ports: clk, rst (sync, active-high), bus (dbram_if.slave: core + loader).
module dbram_responder #(
   parameter int  DEPTH = 4096,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic     clk,
   input  logic     rst,
   dbram_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] PTR_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W:0]   REM_ONE = {{IDX_W{1'b0}}, 1'b1};

   state_t           r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W:0]   r_rem;
   logic             r_busy;
   logic             r_done;
   logic [31:0]      r_dout;
   logic [31:0]      r_mem [DEPTH];

   logic [IDX_W-1:0] w_idx;
   logic             w_in_load;
   logic             w_load_acc;
   logic             w_unused_addr;

   assign w_idx         = bus.addr[IDX_W-1:0];
   assign w_unused_addr = ^bus.addr[29:IDX_W];
   assign w_in_load     = (r_state == S_LOAD);
   // Core request always wins the single write port.
   assign w_load_acc    = w_in_load & bus.load_valid & ~bus.en;

   assign bus.load_ready = w_in_load & ~bus.en;
   assign bus.load_busy  = r_busy;
   assign bus.load_done  = r_done;
   assign bus.data_out   = r_dout;

   // Storage is not reset; w_load_acc already excludes core cycles.
   always_ff @(posedge clk) begin
      if (bus.en) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) begin
               r_mem[w_idx][8*i +: 8] <= bus.data_in[8*i +: 8];
            end
         end
      end else if (w_load_acc) begin
         r_mem[r_ptr] <= bus.load_data;
      end
   end

   // Non-blocking read of the array gives read-first data on writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout <= '0;
      end else if (bus.en) begin
         r_dout <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_rem   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.load_start) begin
                  r_ptr <= bus.load_base;
                  r_rem <= bus.load_len;
                  if (bus.load_len == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_LOAD;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (w_load_acc) begin
                  r_ptr <= r_ptr + PTR_ONE;
                  r_rem <= r_rem - REM_ONE;
                  if (r_rem == REM_ONE) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end
endmodule
